// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the serial pattern detector controller.
package seq_ctrl_pkg;

  localparam int M_DEF     = 8;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A pattern length is usable only when it is non-zero and fits the pattern register.
  function automatic logic len_ok(input logic [3:0] len, input int max_len);
    return (len != 4'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/seq_match.sv
// History shift register, fill tracking and masked compare for one run.
// match is combinational and qualifies the bit being shifted in this cycle.
module seq_match
  import seq_ctrl_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic [M-1:0] pat,
  input  logic [3:0]   len,
  input  logic         ovl,
  output logic         match
);

  localparam int FW = $clog2(M + 1);

  logic [M-1:0]  hist;
  logic [M-1:0]  hist_next;
  logic [M-1:0]  mask;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    hist_next = {hist[M-2:0], bit_in};
    fill_next = (int'(fill) == M) ? fill : fill + FW'(1);
    // len == M wraps the shifted one to zero, giving an all-ones mask.
    mask      = (M'(1) << len) - M'(1);
    match     = shift_en && (int'(fill_next) >= int'(len)) &&
                ((hist_next & mask) == (pat & mask));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      if (match && !ovl) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_next;
        fill <= fill_next;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: counts matches over a window of stream bits.
// Optional run abort input is enabled by defining SEQCTRL_ABORT_EN.
module seq_det_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             g_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [M-1:0]     cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_ovl,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
`ifdef SEQCTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic             cfg_ok;
  logic [M-1:0]     pat_q;
  logic [3:0]       len_q;
  logic             ovl_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] bit_cnt;

  logic abort_req;
  logic start_go;
  logic win_end;
  logic shift_en;
  logic last_bit;
  logic match;

`ifdef SEQCTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    // A same-cycle configuration offer wins over start.
    start_go = (state == ST_IDLE) && start && !cfg_valid && cfg_ok;
    // Only reachable at bit_cnt == 0 for a zero-length window.
    win_end  = (bit_cnt == win_q);
    shift_en = (state == ST_RUN) && !abort_req && !win_end && bit_valid;
    last_bit = ((bit_cnt + WIN_W'(1)) == win_q);
  end

  seq_match #(.M(M)) u_match (
    .clk      (clk),
    .rst_n    (g_rst_n),
    .clr      (start_go),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .pat      (pat_q),
    .len      (len_q),
    .ovl      (ovl_q),
    .match    (match)
  );

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state     <= ST_IDLE;
      cfg_ok    <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      win_q     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      hit       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (len_ok(cfg_len, M)) begin
              pat_q  <= cfg_pat;
              len_q  <= cfg_len;
              ovl_q  <= cfg_ovl;
              win_q  <= cfg_win;
              cfg_ok <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (start) begin
            if (start_go) begin
              state     <= ST_RUN;
              bit_cnt   <= '0;
              match_cnt <= '0;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_req || win_end) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (shift_en) begin
            bit_cnt <= bit_cnt + WIN_W'(1);
            if (match) begin
              hit <= 1'b1;
              if (match_cnt != {CNT_W{1'b1}}) match_cnt <= match_cnt + CNT_W'(1);
            end
            if (last_bit) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized bench for seq_det_ctrl against a window-level reference model.
// Runs a default instance and a CNT_W=2 instance side by side on shared stimulus.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        g_rst_n;
  logic        cfg_valid;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        cfg_ovl;
  logic [15:0] cfg_win;
  logic        start;
  logic        bit_valid;
  logic        bit_in;
`ifdef SEQCTRL_ABORT_EN
  logic        abort;
`endif

  logic       cfg_ready, busy, hit, done, err;
  logic [7:0] match_cnt;
  logic       cfg_ready_s, busy_s, hit_s, done_s, err_s;
  logic [1:0] match_cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk(clk), .g_rst_n(g_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cfg_win(cfg_win),
    .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef SEQCTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .hit(hit), .match_cnt(match_cnt), .done(done), .err(err)
  );

  seq_det_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .g_rst_n(g_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cfg_win(cfg_win),
    .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef SEQCTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_s), .hit(hit_s), .match_cnt(match_cnt_s), .done(done_s), .err(err_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: scan the gapless stream; a match needs len unconsumed bits whose
  // last len values spell the pattern (pattern bit len-1 is the earliest).
  function automatic int model_count(input logic [63:0] stream, input int n,
                                     input logic [7:0] pat, input int len,
                                     input logic ovl, output logic [63:0] hits);
    int avail = 0;
    int cnt   = 0;
    hits = '0;
    for (int i = 0; i < n; i++) begin
      logic ok;
      avail++;
      if (avail >= len) begin
        ok = 1'b1;
        for (int k = 0; k < len; k++) if (stream[i-k] != pat[k]) ok = 1'b0;
        if (ok) begin
          hits[i] = 1'b1;
          cnt++;
          if (!ovl) avail = 0;
        end
      end
    end
    return cnt;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [15:0] win, input logic exp_err);
    cfg_valid = 1'b1; cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; cfg_win = win;
    tick();
    cfg_valid = 1'b0;
    check("cfg_err", err, exp_err);
    check("cfg_err_sat", err_s, exp_err);
    check("cfg_busy", busy, 1'b0);
  endtask

  // Runs one window with the configuration already stored in the DUT.
  task automatic run_stream(input logic [7:0] pat, input int len, input logic ovl,
                            input int win, input logic [63:0] stream,
                            input int max_gap, input int abort_at);
    logic [63:0] hits;
    int exp_cnt, exp_sat, n;
    n = (abort_at >= 0 && abort_at < win) ? abort_at : win;
    exp_cnt = model_count(stream, n, pat, len, ovl, hits);
    exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", busy, 1'b1);
    check("run_cfg_ready", cfg_ready, 1'b0);
    check("run_cnt_clr", match_cnt, 0);

    for (int i = 0; i < n; i++) begin
      int gaps = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bit_valid = 1'b0; bit_in = 1'($urandom); start = 1'($urandom);
        tick();
        start = 1'b0;
        check("gap_hit", hit, 1'b0);
        check("gap_done", done, 1'b0);
      end
      // start and a junk config offer are both ignored while running
      bit_valid = 1'b1; bit_in = stream[i]; start = 1'($urandom);
      cfg_valid = 1'($urandom); cfg_len = 4'($urandom);
      tick();
      bit_valid = 1'b0; start = 1'b0; cfg_valid = 1'b0;
      check("bit_hit", hit, hits[i]);
      check("bit_hit_sat", hit_s, hits[i]);
      check("bit_done", done, (i == win - 1));
    end

`ifdef SEQCTRL_ABORT_EN
    if (abort_at >= 0 && abort_at < win) begin
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'($urandom);
      tick();
      abort = 1'b0; bit_valid = 1'b0;
      check("abort_done", done, 1'b1);
      check("abort_hit", hit, 1'b0);
      check("abort_busy", busy, 1'b0);
    end
`endif
    if (win == 0) begin
      tick();
      check("win0_done", done, 1'b1);
    end

    check("end_cnt", match_cnt, exp_cnt);
    check("end_cnt_sat", match_cnt_s, exp_sat);
    tick();
    check("idle_done", done, 1'b0);
    check("idle_ready", cfg_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_cnt_hold", match_cnt, exp_cnt);
  endtask

  initial begin
    logic [63:0] s;
    g_rst_n = 1'b0; cfg_valid = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    cfg_win = '0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
`ifdef SEQCTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cnt", match_cnt, 0);
    g_rst_n = 1'b1;
    tick();

    // Illegal lengths, then a start with no valid configuration
    do_cfg(8'h05, 4'd0, 1'b1, 16'd5, 1'b1);
    do_cfg(8'h05, 4'd9, 1'b1, 16'd5, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nocfg_err", err, 1'b1);
    check("nocfg_busy", busy, 1'b0);
    check("nocfg_ready", cfg_ready, 1'b1);
    tick();
    check("err_pulse", err, 1'b0);

    // 101 overlapping; a rejected offer must leave the stored config alone
    do_cfg(8'b101, 4'd3, 1'b1, 16'd5, 1'b0);
    do_cfg(8'hFF, 4'd9, 1'b0, 16'd2, 1'b1);
    run_stream(8'b101, 3, 1'b1, 5, 64'b10101, 0, -1);
    check("ovl_cnt", match_cnt, 2);

    do_cfg(8'b101, 4'd3, 1'b0, 16'd5, 1'b0);
    run_stream(8'b101, 3, 1'b0, 5, 64'b10101, 0, -1);
    check("novl_cnt", match_cnt, 1);

    do_cfg(8'b101, 4'd3, 1'b1, 16'd0, 1'b0);
    run_stream(8'b101, 3, 1'b1, 0, 64'b10101, 0, -1);

    // Gapped stream on a 5-bit pattern, both overlap modes
    for (int o = 0; o < 2; o++) begin
      s = {$urandom, $urandom};
      s[4:0] = 5'b10110;  // time order 0,1,1,0,1 spells 01101
      do_cfg(8'b01101, 4'd5, 1'(o), 16'd10, 1'b0);
      run_stream(8'b01101, 5, 1'(o), 10, s, 3, -1);
    end

    // Saturation of the narrow counter
    do_cfg(8'b1, 4'd1, 1'b0, 16'd6, 1'b0);
    run_stream(8'b1, 1, 1'b0, 6, 64'h3F, 0, -1);
    check("sat_cnt", match_cnt_s, 2'd3);
    check("wide_cnt", match_cnt, 6);

    // cfg_valid and start together: config taken, start dropped
    cfg_valid = 1'b1; start = 1'b1; cfg_pat = 8'b11; cfg_len = 4'd2; cfg_ovl = 1'b1;
    cfg_win = 16'd7;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    check("both_busy", busy, 1'b0);
    check("both_err", err, 1'b0);
    check("both_ready", cfg_ready, 1'b1);
    run_stream(8'b11, 2, 1'b1, 7, 64'b1101111, 1, -1);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] p;
      int l, w;
      logic ov;
      p  = 8'($urandom);
      l  = $urandom_range(1, 8);
      w  = $urandom_range(0, 40);
      ov = 1'($urandom);
      s  = {$urandom, $urandom};
      // Bias some runs toward frequent matches by using a tiny pattern
      if (r % 3 == 0) l = $urandom_range(1, 2);
      do_cfg(p, 4'(l), ov, 16'(w), 1'b0);
      run_stream(p, l, ov, w, s, 2, -1);
    end

`ifdef SEQCTRL_ABORT_EN
    s = {$urandom, $urandom};
    s[2:0] = 3'b101;
    do_cfg(8'b101, 4'd3, 1'b1, 16'd8, 1'b0);
    run_stream(8'b101, 3, 1'b1, 8, s, 0, 3);
    check("abort_cnt", match_cnt, 1);
    // abort outside RUN is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_done", done, 1'b0);
    check("abort_idle_busy", busy, 1'b0);
`endif

    // Reset in the middle of a run
    do_cfg(8'b1, 4'd1, 1'b1, 16'd8, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    check("pre_rst_cnt", match_cnt, 2);
    #2 g_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", cfg_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hit", hit, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_cnt", match_cnt, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_hold_done", done, 1'b0);
    end
    g_rst_n = 1'b1;
    tick();
    check("post_rst_done", done, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_err", err, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
